// File: rtl/register_window_pkg.sv
// register_window_pkg: shared width, region bases and address-region decode for the register window
package register_window_pkg;
  localparam int DATA_W = 32;
  localparam logic [4:0] GLB_BASE = 5'd0;
  localparam logic [4:0] OUT_BASE = 5'd8;
  localparam logic [4:0] LOC_BASE = 5'd16;
  localparam logic [4:0] IN_BASE = 5'd24;
  typedef logic [DATA_W-1:0] word_t;
  typedef enum logic [1:0] {RG_GLB, RG_OUT, RG_LOC, RG_IN} region_e;
  function automatic region_e region(input logic [4:0] a);
    return a >= IN_BASE ? RG_IN : a >= LOC_BASE ? RG_LOC : a >= OUT_BASE ? RG_OUT : RG_GLB;
  endfunction
endpackage

// File: rtl/register_window_if.sv
// register_window_if: read/write bus of one register window, including neighbour and global links
interface register_window_if;
  import register_window_pkg::*;
  logic RFE;
  logic [7:0] RE;
  logic [4:0] RA, RB;
  logic WE, WEx, BE3, BE2, BE1;
  word_t in, GA, GB, AxIn, BxIn;
  word_t Aout, Bout, AxOut, BxOut;
  modport master(output RFE, RE, RA, RB, WE, WEx, BE3, BE2, BE1, in, GA, GB, AxIn, BxIn,
                 input Aout, Bout, AxOut, BxOut);
  modport slave(input RFE, RE, RA, RB, WE, WEx, BE3, BE2, BE1, in, GA, GB, AxIn, BxIn,
                output Aout, Bout, AxOut, BxOut);
endinterface

// File: rtl/register_window_reg_bank8.sv
// reg_bank8: 8-entry bank with sync reset, one write port and two combinational read ports
module reg_bank8
  import register_window_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [2:0] waddr,
  input  word_t      wdata,
  input  logic [2:0] raddr_a,
  input  logic [2:0] raddr_b,
  output word_t      rdata_a,
  output word_t      rdata_b
);
  word_t mem_q [8];
  word_t mem_d [8];
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end
  always_ff @(posedge clk)
    for (int i = 0; i < 8; i++) mem_q[i] <= rst ? '0 : mem_d[i];
  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];
endmodule

// File: rtl/register_window.sv
// register_window: SPARC window (locals+ins) with read mux; REGWIN_BYPASS_EN enables write-through forwarding
module register_window
  import register_window_pkg::*;
(
  input logic Clk,
  input logic Reset,
  register_window_if.slave bus
);
`ifdef REGWIN_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  region_e ra_rg, rb_rg;
  logic wr_in, wr_loc, en_a, en_b;
  word_t loc_rd_a, loc_rd_b, ins_rd_a, ins_rd_b, loc_a, loc_b, ins_a, ins_b;
  function automatic word_t rd_mux(input logic en, input region_e r, input word_t g, x, l, i);
    return !en ? '0 : r == RG_GLB ? g : r == RG_OUT ? x : r == RG_LOC ? l : i;
  endfunction
  assign ra_rg = region(bus.RA);
  assign rb_rg = region(bus.RB);
  // neighbour writes to its outs (RA 8..15) land in our ins
  assign wr_in = bus.RFE & ((bus.WE & bus.BE3 & (ra_rg == RG_IN)) | (bus.WEx & bus.BE1 & (ra_rg == RG_OUT)));
  assign wr_loc = bus.RFE & bus.WE & bus.BE2 & (ra_rg == RG_LOC);
  reg_bank8 u_loc (
    .clk(Clk), .rst(Reset), .we(wr_loc), .waddr(bus.RA[2:0]), .wdata(bus.in),
    .raddr_a(bus.RA[2:0]), .raddr_b(bus.RB[2:0]), .rdata_a(loc_rd_a), .rdata_b(loc_rd_b)
  );
  reg_bank8 u_ins (
    .clk(Clk), .rst(Reset), .we(wr_in), .waddr(bus.RA[2:0]), .wdata(bus.in),
    .raddr_a(bus.RA[2:0]), .raddr_b(bus.RB[2:0]), .rdata_a(ins_rd_a), .rdata_b(ins_rd_b)
  );
  // port A always addresses the write target, port B only when the low index matches
  always_comb begin
    loc_a = BYP && wr_loc ? bus.in : loc_rd_a;
    loc_b = BYP && wr_loc && bus.RB[2:0] == bus.RA[2:0] ? bus.in : loc_rd_b;
    ins_a = BYP && wr_in ? bus.in : ins_rd_a;
    ins_b = BYP && wr_in && bus.RB[2:0] == bus.RA[2:0] ? bus.in : ins_rd_b;
    en_a = bus.RFE & bus.RE[bus.RA[4:2]];
    en_b = bus.RFE & bus.RE[bus.RB[4:2]];
    bus.Aout = rd_mux(en_a, ra_rg, bus.GA, bus.AxIn, loc_a, ins_a);
    bus.Bout = rd_mux(en_b, rb_rg, bus.GB, bus.BxIn, loc_b, ins_b);
    bus.AxOut = bus.RFE ? ins_a : '0;
    bus.BxOut = bus.RFE ? ins_b : '0;
  end
endmodule

// File: tb/tb_register_window.sv
// tb_register_window: scoreboard bench for register_window, expectations queued at stimulus time
module tb_register_window;
  import register_window_pkg::*;
`ifdef REGWIN_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    string tag;
    int    sel;
    word_t exp;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int n_tests = 0;
  int n_fail = 0;
  exp_t sb[$];
  register_window_if bus();
  register_window dut (.Clk(clk), .Reset(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input word_t got, input word_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic push(input string tag, input int sel, input word_t exp);
    sb.push_back('{tag, sel, exp});
  endtask
  task automatic drain;
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, e.sel == 0 ? bus.Aout : e.sel == 1 ? bus.Bout : e.sel == 2 ? bus.AxOut : bus.BxOut, e.exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  initial begin
    rst = 1'b1;
    bus.RFE = 1'b1; bus.RE = 8'hFF; bus.RA = 5'd31; bus.RB = 5'd31;
    bus.WE = 0; bus.WEx = 0; bus.BE3 = 0; bus.BE2 = 0; bus.BE1 = 0;
    bus.in = '0; bus.GA = '0; bus.GB = '0; bus.AxIn = '0; bus.BxIn = '0;
    tick;
    rst = 1'b0;
    push("rst_aout", 0, '0); push("rst_bout", 1, '0); push("rst_axout", 2, '0); push("rst_bxout", 3, '0);
    drain;
    bus.WE = 1; bus.BE3 = 1; bus.in = 32'h0000_1111;
    push("pre_ins7_aout", 0, BYP ? 32'h0000_1111 : '0);
    push("pre_ins7_axout", 2, BYP ? 32'h0000_1111 : '0);
    drain;
    tick;
    bus.WE = 0;
    push("ins7_aout", 0, 32'h0000_1111); push("ins7_axout", 2, 32'h0000_1111); push("ins7_bxout", 3, 32'h0000_1111);
    drain;
    bus.RE[7] = 1'b0;
    push("re7_aout", 0, '0); push("re7_axout", 2, 32'h0000_1111);
    drain;
    bus.RE = 8'hFF; bus.BE3 = 0;
    bus.WE = 1; bus.BE2 = 1; bus.RA = 5'd16; bus.in = 32'hCAFE_0001;
    tick;
    bus.WE = 0; bus.BE2 = 0; bus.RB = 5'd16;
    push("loc0_bout", 1, 32'hCAFE_0001); push("loc0_aout", 0, 32'hCAFE_0001);
    drain;
    bus.RE[4] = 1'b0;
    push("re4_bout", 1, '0);
    drain;
    bus.RE = 8'hFF;
    bus.WE = 1; bus.RA = 5'd26; bus.in = 32'hDEAD_0000;
    tick;
    bus.WE = 0; bus.RB = 5'd26;
    push("be3off_bout", 1, '0); push("be3off_bxout", 3, '0);
    drain;
    bus.WEx = 1; bus.BE1 = 1; bus.RA = 5'd10;
    tick;
    bus.WEx = 0; bus.BE1 = 0; bus.AxIn = 32'hA5A5_A5A5;
    push("wex_bout", 1, 32'hDEAD_0000); push("wex_axout", 2, 32'hDEAD_0000); push("out_aout", 0, 32'hA5A5_A5A5);
    drain;
    bus.WE = 1; bus.BE2 = 1; bus.RA = 5'd29; bus.in = 32'h1111_2222;
    tick;
    bus.WE = 0; bus.BE2 = 0;
    push("be2_ins_aout", 0, '0);
    drain;
    bus.RA = 5'd3; bus.GA = 32'h1234_5678; bus.RB = 5'd12; bus.BxIn = 32'h0BAD_F00D;
    push("glb_aout", 0, 32'h1234_5678); push("out_bout", 1, 32'h0BAD_F00D);
    push("ins3_axout", 2, '0); push("ins4_bxout", 3, '0);
    drain;
    bus.RFE = 0; bus.RA = 5'd31; bus.RB = 5'd26;
    push("rfe0_aout", 0, '0); push("rfe0_bout", 1, '0); push("rfe0_axout", 2, '0); push("rfe0_bxout", 3, '0);
    drain;
    bus.WE = 1; bus.BE2 = 1; bus.RA = 5'd17; bus.in = 32'h0000_0077;
    tick;
    bus.RFE = 1; bus.WE = 0; bus.BE2 = 0;
    push("rfe0_nowrite", 0, '0);
    drain;
    bus.WE = 1; bus.BE2 = 1; bus.RA = 5'd20; bus.RB = 5'd20; bus.in = 32'h55AA_55AA;
    push("byp_loc4_bout", 1, BYP ? 32'h55AA_55AA : '0);
    drain;
    rst = 1'b1;
    tick;
    rst = 1'b0; bus.WE = 0; bus.BE2 = 0;
    push("rst_loc4_bout", 1, '0);
    drain;
    bus.RA = 5'd31; bus.RB = 5'd16;
    push("rst2_ins7_aout", 0, '0); push("rst2_axout", 2, '0); push("rst2_loc0_bout", 1, '0);
    drain;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
